// File: rtl/sort8_seq_ctrl.sv
// sort8_seq_ctrl: eight-word sorter built from a single sort4 network that is
// reused over five passes. The result matches a full sort8 merge network.
// Words arrive as a serial stream and are loaded into r0..r7. The block then
// runs the five passes and unloads the sorted words as a serial stream.
//
// Ports:
//   clk, rst_n            rising-edge clock; asynchronous active-low reset
//   flush                 synchronous abort; returns to LOAD on the next edge
//   in_valid/in_ready/in_data      producer handshake (in_ready only in LOAD)
//   out_valid/out_ready/out_data   consumer handshake (out_valid only in OUT)
//   out_last              high while the 8th output word is presented
//   busy                  high in SORT or OUT
//   done                  1-cycle pulse in the cycle after the last output handshake
//
// Build option: define SORT8_CTRL_DESC_EN to unload largest-first
// (out_data = r[7-idx]). Pass sequencing and latency do not change.

module sort4 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [W-1:0] o0,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3
);
    logic [W-1:0] a0, a1, a2, a3, b1, b2;

    // Five compare-exchange elements: (0,1) (2,3), then (0,2) (1,3), then (1,2).
    assign a0 = (i0 < i1) ? i0 : i1;
    assign a1 = (i0 < i1) ? i1 : i0;
    assign a2 = (i2 < i3) ? i2 : i3;
    assign a3 = (i2 < i3) ? i3 : i2;
    assign o0 = (a0 < a2) ? a0 : a2;
    assign b2 = (a0 < a2) ? a2 : a0;
    assign b1 = (a1 < a3) ? a1 : a3;
    assign o3 = (a1 < a3) ? a3 : a1;
    assign o1 = (b1 < b2) ? b1 : b2;
    assign o2 = (b1 < b2) ? b2 : b1;
endmodule

module sort8_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int NUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    if (DATA_W != 8 || NUM_W != 8) begin : g_bad_cfg
        $error("sort8_seq_ctrl supports only DATA_W=8, NUM_W=8");
    end

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t                  state, state_n;
    logic [7:0][DATA_W-1:0]  r;
    logic [2:0]              idx;
    logic [2:0]              pass;
    logic [DATA_W-1:0]       s_in [4];
    logic [DATA_W-1:0]       s_out [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (in_valid && idx == 3'd7) state_n = SORT;
            SORT:    if (pass == 3'd4) state_n = OUT;
            OUT:     if (out_ready && idx == 3'd7) state_n = LOAD;
            default: state_n = LOAD;
        endcase
        if (flush) state_n = LOAD;
    end

    // Select which four registers the shared network sees on this pass.
    always_comb begin
        s_in[0] = r[0]; s_in[1] = r[1]; s_in[2] = r[2]; s_in[3] = r[3];
        case (pass)
            3'd1:    begin s_in[0] = r[4]; s_in[1] = r[5]; s_in[2] = r[6]; s_in[3] = r[7]; end
            3'd2:    begin s_in[0] = r[0]; s_in[1] = r[1]; s_in[2] = r[4]; s_in[3] = r[5]; end
            3'd3:    begin s_in[0] = r[2]; s_in[1] = r[3]; s_in[2] = r[6]; s_in[3] = r[7]; end
            3'd4:    begin s_in[0] = r[4]; s_in[1] = r[5]; s_in[2] = r[2]; s_in[3] = r[3]; end
            default: ;
        endcase
    end

    sort4 #(.W(DATA_W)) u_sort4 (
        .i0(s_in[0]), .i1(s_in[1]), .i2(s_in[2]), .i3(s_in[3]),
        .o0(s_out[0]), .o1(s_out[1]), .o2(s_out[2]), .o3(s_out[3])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            idx  <= '0;
            pass <= '0;
            done <= 1'b0;
        end else if (flush) begin
            // Storage is left stale; the next frame overwrites all eight words.
            idx  <= '0;
            pass <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    pass <= '0;
                    if (in_valid) begin
                        r[idx] <= in_data;
                        idx    <= idx + 3'd1;
                    end
                end
                SORT: begin
                    pass <= pass + 3'd1;
                    case (pass)
                        3'd0: begin r[0] <= s_out[0]; r[1] <= s_out[1]; r[2] <= s_out[2]; r[3] <= s_out[3]; end
                        3'd1: begin r[4] <= s_out[0]; r[5] <= s_out[1]; r[6] <= s_out[2]; r[7] <= s_out[3]; end
                        3'd2: begin r[0] <= s_out[0]; r[1] <= s_out[1]; r[4] <= s_out[2]; r[5] <= s_out[3]; end
                        3'd3: begin r[2] <= s_out[0]; r[3] <= s_out[1]; r[6] <= s_out[2]; r[7] <= s_out[3]; end
                        default: begin
                            // Final pass merges the four middle-rank words into r2..r5.
                            r[2] <= s_out[0]; r[3] <= s_out[1]; r[4] <= s_out[2]; r[5] <= s_out[3];
                            idx  <= '0;
                            pass <= '0;
                        end
                    endcase
                end
                OUT: begin
                    if (out_ready) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) done <= 1'b1;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == OUT);
    assign busy      = (state != LOAD);
    assign out_last  = (state == OUT) && (idx == 3'd7);
`ifdef SORT8_CTRL_DESC_EN
    assign out_data  = r[3'd7 - idx];
`else
    assign out_data  = r[idx];
`endif
endmodule

// File: tb/tb_sort8_seq_ctrl.sv
module tb_sort8_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    logic [7:0] frame [8];
    logic [7:0] exp_q [$];

    sort8_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: the sorted multiset of the frame, in unload order.
    task automatic build_expected();
        exp_q = {};
        for (int i = 0; i < 8; i++) exp_q.push_back(frame[i]);
`ifdef SORT8_CTRL_DESC_EN
        exp_q.rsort();
`else
        exp_q.sort();
`endif
    endtask

    // Starts at a negedge in LOAD; ends at the negedge where out_valid is first seen.
    task automatic send_frame(input bit garbage, output int lat);
        build_expected();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i];
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL in_ready word=%0d got=%b exp=1", i, in_ready);
            end
            @(negedge clk);
        end
        in_valid = garbage;
        in_data  = 8'($urandom);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL sort_state busy=%b in_ready=%b exp 1/0", busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            in_data = 8'($urandom);
            lat++;
        end
    endtask

    // mode 0: always ready, 1: pattern 1-0-0-1, 2: random
    task automatic recv_frame(input int mode);
        int k = 0;
        int n = 0;
        bit rdy;
        while (k < 8 && n < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 4 == 0) || (n % 4 == 3);
                default: rdy = 1'($urandom);
            endcase
            out_ready = rdy;
            if (rdy && k == 7) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == 7)) begin
                failures++;
                $display("FAIL out_word k=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         k, out_valid, out_data, out_last, exp_q[k], (k == 7));
            end
            if (rdy) k++;
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (k != 8 || done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse k=%0d got done=%b ov=%b ir=%b exp k=8 1/0/1", k, done, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL done_width got=%b exp=0", done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset got ir=%b ov=%b ol=%b busy=%b done=%b exp 1/0/0/0/0",
                     in_ready, out_valid, out_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        frame = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        send_frame(1'b0, lat);
        checks++;
        if (lat != 5) begin
            failures++; $display("FAIL latency got=%0d exp=5", lat);
        end
        recv_frame(0);
    endtask

    task automatic test_extremes();
        int lat;
        frame = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h00};
        send_frame(1'b0, lat);
        recv_frame(0);
    endtask

    task automatic test_backpressure();
        int lat;
        frame = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        send_frame(1'b1, lat);
        recv_frame(1);
    endtask

    task automatic test_flush();
        // Accept 8 words, then flush while pass 2 is pending.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL flush_idle c=%0d got ir=%b ov=%b busy=%b exp 1/0/0", c, in_ready, out_valid, busy);
            end
            @(negedge clk);
        end
        frame = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        begin
            int lat;
            send_frame(1'b0, lat);
            recv_frame(0);
        end
        // Partial frame flushed, with a same-cycle input offer that must be dropped.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hEE;
            @(negedge clk);
        end
        flush = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 8; i++) frame[i] = 8'($urandom_range(0, 40));
        begin
            int lat;
            send_frame(1'b0, lat);
            recv_frame(2);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        for (int i = 0; i < 8; i++) frame[i] = 8'($urandom);
        send_frame(1'b0, lat);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_data !== exp_q[2]) begin
            failures++; $display("FAIL third_word got=%h exp=%h", out_data, exp_q[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got ir=%b ov=%b ol=%b busy=%b done=%b exp 1/0/0/0/0",
                     in_ready, out_valid, out_last, busy, done);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset got done=%b ov=%b exp 0/0", done, out_valid);
        end
        for (int i = 0; i < 8; i++) frame[i] = 8'($urandom);
        send_frame(1'b0, lat);
        recv_frame(0);
    endtask

    task automatic test_random();
        int lat;
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 8; i++)
                frame[i] = (f % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send_frame(1'b1, lat);
            checks++;
            if (lat != 5) begin
                failures++; $display("FAIL rand_latency frame=%0d got=%0d exp=5", f, lat);
            end
            recv_frame(2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
